// File: rtl/mixed_clock_fifo.sv
// Circular FIFO with arbitrary depth, occupancy count, full/empty flags,
// a registered read port and a synchronous flush that clears all storage.
module mixed_clock_fifo #(
   parameter int unsigned CAPACITY  = 3,
   parameter int unsigned BIT_WIDTH = 8
) (
   output logic [BIT_WIDTH-1:0]               data_out,
   output logic [$clog2(CAPACITY+1)-1:0]      population,
   output logic                               full,
   output logic                               empty,
   input  logic [BIT_WIDTH-1:0]               data_in,
   input  logic                               enqueue,
   input  logic                               dequeue,
   input  logic                               flush,
   input  logic                               clock,
   input  logic                               reset_n
);

   localparam int unsigned PTR_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
   localparam int unsigned CNT_W = $clog2(CAPACITY+1);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(CAPACITY - 1);
   localparam logic [CNT_W-1:0] CAP_CNT   = CNT_W'(CAPACITY);

   logic [BIT_WIDTH-1:0] buffer [0:CAPACITY-1];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 enq_ok;
   logic                 deq_ok;

   assign full   = (population == CAP_CNT);
   assign empty  = (population == '0);
   // Acceptance uses only the pre-edge flags, so a full FIFO rejects writes
   // even when a read frees a slot on the same edge.
   assign enq_ok = enqueue && !full;
   assign deq_ok = dequeue && !empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out   <= '0;
         population <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         for (int i = 0; i < int'(CAPACITY); i++) buffer[i] <= '0;
      end else if (flush) begin
         data_out   <= '0;
         population <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         for (int i = 0; i < int'(CAPACITY); i++) buffer[i] <= '0;
      end else begin
         if (enq_ok) begin
            buffer[wr_ptr] <= data_in;
            wr_ptr         <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (deq_ok) begin
            data_out <= buffer[rd_ptr];
            rd_ptr   <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_W'(1);
         end
         if (enq_ok && !deq_ok) begin
            population <= population + CNT_W'(1);
         end else if (deq_ok && !enq_ok) begin
            population <= population - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mixed_clock_fifo.sv
// Directed bench for mixed_clock_fifo: a queue-based reference model checked
// every falling edge, plus literal expectations at key points.
module tb_mixed_clock_fifo;

   localparam int CAP = 3;
   localparam int BW  = 8;

   logic [BW-1:0] data_out;
   logic [1:0]    population;
   logic          full;
   logic          empty;
   logic [BW-1:0] data_in;
   logic          enqueue;
   logic          dequeue;
   logic          flush;
   logic          clock;
   logic          reset_n;

   int tests = 0;
   int fails = 0;

   mixed_clock_fifo #(
      .CAPACITY  (CAP),
      .BIT_WIDTH (BW)
   ) dut (
      .data_out   (data_out),
      .population (population),
      .full       (full),
      .empty      (empty),
      .data_in    (data_in),
      .enqueue    (enqueue),
      .dequeue    (dequeue),
      .flush      (flush),
      .clock      (clock),
      .reset_n    (reset_n)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of stored words and the last dequeued word.
   logic [BW-1:0] m_q[$];
   logic [BW-1:0] m_dout = '0;

   always @(negedge reset_n) begin
      m_q.delete();
      m_dout = '0;
   end

   always @(posedge clock) begin
      if (reset_n) begin
         if (flush) begin
            m_q.delete();
            m_dout = '0;
         end else begin
            bit take_w, take_r;
            take_w = enqueue && (m_q.size() < CAP);
            take_r = dequeue && (m_q.size() > 0);
            if (take_r) m_dout = m_q.pop_front();
            if (take_w) m_q.push_back(data_in);
         end
      end
   end

   always @(negedge clock) begin
      chk("model_data_out", 32'(data_out), 32'(m_dout));
      chk("model_population", 32'(population), 32'(m_q.size()));
      chk("model_full", 32'(full), 32'(m_q.size() == CAP));
      chk("model_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("population_bound", 32'(population <= 2'(CAP)), 32'd1);
   end

   task automatic step(input logic en, input logic de, input logic fl, input logic [BW-1:0] d);
      @(negedge clock);
      enqueue = en;
      dequeue = de;
      flush   = fl;
      data_in = d;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_buf(input string name, input int b0, input int b1, input int b2);
      chk({name, "_buf0"}, 32'(dut.buffer[0]), 32'(b0));
      chk({name, "_buf1"}, 32'(dut.buffer[1]), 32'(b1));
      chk({name, "_buf2"}, 32'(dut.buffer[2]), 32'(b2));
   endtask

   initial begin
      reset_n = 1'b0;
      enqueue = 1'b0;
      dequeue = 1'b0;
      flush   = 1'b0;
      data_in = '0;
      #1;
      // 1. reset
      chk("rst_pop", 32'(population), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_dout", 32'(data_out), 0);
      chk_buf("rst", 0, 0, 0);
      @(negedge clock);
      reset_n = 1'b1;

      // 2. fill
      step(1, 0, 0, 100);
      chk("fill1_pop", 32'(population), 1);
      chk("fill1_empty", 32'(empty), 0);
      step(1, 0, 0, 255);
      chk("fill2_pop", 32'(population), 2);
      step(1, 0, 0, 120);
      chk("fill3_pop", 32'(population), 3);
      chk("fill3_full", 32'(full), 1);
      chk_buf("fill", 100, 255, 120);

      // 3. overflow and drain
      step(1, 0, 0, 7);
      chk("ovf_pop", 32'(population), 3);
      chk_buf("ovf", 100, 255, 120);
      step(0, 1, 0, 0);
      chk("drain1_dout", 32'(data_out), 100);
      chk("drain1_pop", 32'(population), 2);
      chk("drain1_full", 32'(full), 0);
      step(0, 1, 0, 0);
      chk("drain2_dout", 32'(data_out), 255);
      chk("drain2_pop", 32'(population), 1);
      step(0, 1, 0, 0);
      chk("drain3_dout", 32'(data_out), 120);
      chk("drain3_pop", 32'(population), 0);
      step(0, 1, 0, 0);
      chk("drain4_dout", 32'(data_out), 120);
      chk("drain4_empty", 32'(empty), 1);

      // 4. wrap-around: slots 0,1,2 then 0,1 again
      step(1, 0, 0, 1);
      for (int v = 2; v <= 5; v++) begin
         step(1, 1, 0, 8'(v));
         chk("wrap_dout", 32'(data_out), 32'(v - 1));
         chk("wrap_pop", 32'(population), 1);
      end
      step(0, 1, 0, 0);
      chk("wrap_last_dout", 32'(data_out), 5);
      chk("wrap_last_empty", 32'(empty), 1);

      // 5. simultaneous events
      step(1, 0, 0, 9);
      step(1, 1, 0, 10);
      chk("sim1_dout", 32'(data_out), 9);
      chk("sim1_pop", 32'(population), 1);
      step(1, 0, 0, 11);
      step(1, 0, 0, 12);
      chk("sim2_full", 32'(full), 1);
      step(1, 1, 0, 13);
      chk("sim2_dout", 32'(data_out), 10);
      chk("sim2_pop", 32'(population), 2);
      step(0, 1, 0, 0);
      chk("sim2_d11", 32'(data_out), 11);
      step(0, 1, 0, 0);
      chk("sim2_d12", 32'(data_out), 12);
      chk("sim2_empty", 32'(empty), 1);
      step(1, 1, 0, 14);
      chk("sim3_pop", 32'(population), 1);
      chk("sim3_dout", 32'(data_out), 12);

      // 6. flush and reset mid-stream
      step(1, 0, 0, 15);
      chk("pre_flush_pop", 32'(population), 2);
      step(1, 0, 1, 16);
      chk("flush_pop", 32'(population), 0);
      chk("flush_dout", 32'(data_out), 0);
      chk("flush_empty", 32'(empty), 1);
      chk_buf("flush", 0, 0, 0);
      step(1, 0, 0, 17);
      step(1, 0, 0, 18);
      step(0, 1, 0, 0);
      chk("post_flush_dout", 32'(data_out), 17);
      chk("post_flush_pop", 32'(population), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_pop", 32'(population), 0);
      chk("async_rst_dout", 32'(data_out), 0);
      chk("async_rst_empty", 32'(empty), 1);
      chk("async_rst_full", 32'(full), 0);
      chk_buf("async_rst", 0, 0, 0);
      @(negedge clock);
      reset_n = 1'b1;
      step(1, 0, 0, 42);
      chk("after_rst_pop", 32'(population), 1);
      step(0, 1, 0, 0);
      chk("after_rst_dout", 32'(data_out), 42);
      step(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mixed_clock_fifo.md
# mixed_clock_fifo

Single-clock circular FIFO with occupancy reporting, full/empty flags, a registered read port and a synchronous flush. It buffers `BIT_WIDTH`-bit words between a producer and a consumer that share `clock`. The depth is set by `CAPACITY` and need not be a power of two. The storage array and occupancy counter are internal registers named `buffer` and `population` so benches can probe them hierarchically.

## Interface
- `CAPACITY`, default 3: number of storage slots, must be ≥ 1.
- `BIT_WIDTH`, default 8: width of each word.
- `clock` input, 1 bit: single clock for all state; rising-edge active.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `data_out` output, `BIT_WIDTH` bits: word most recently dequeued (registered).
- `population` output, `$clog2(CAPACITY+1)` bits: number of words currently stored.
- `full` output, 1 bit: high when `population == CAPACITY`.
- `empty` output, 1 bit: high when `population == 0`.
- `data_in` input, `BIT_WIDTH` bits: word to enqueue.
- `enqueue` input, 1 bit: write request.
- `dequeue` input, 1 bit: read request.
- `flush` input, 1 bit: synchronous clear of the FIFO contents.
- Positional port order on instantiation: `data_out, population, full, empty, data_in, enqueue, dequeue, flush, clock, reset_n`.
- Parameter order on instantiation: `CAPACITY, BIT_WIDTH`.

## Operation
- Storage is `buffer[0:CAPACITY-1]`, with write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(CAPACITY)` bits wide (minimum 1).
- Pointers increment and wrap from `CAPACITY-1` to 0 using an explicit compare, not power-of-two overflow.
- Enqueue accepted = `enqueue && !full`.
  - `buffer[wr_ptr] <= data_in` and `wr_ptr` advances.
- Dequeue accepted = `dequeue && !empty`.
  - `data_out <= buffer[rd_ptr]` and `rd_ptr` advances.
  - The vacated slot keeps its old value.
- Acceptance is decided from the pre-edge `full`/`empty` only.
  - When full, enqueue is ignored even if a dequeue is accepted in the same cycle.
  - When empty, dequeue is ignored even if an enqueue is accepted in the same cycle.
- Population update per cycle:
  - +1 for enqueue only.
  - −1 for dequeue only.
  - Unchanged when both or neither are accepted.
- Both accepted in one cycle: the write and the read proceed independently, to different slots.
- Rejected requests change no state, including `data_out`.
- `flush` has priority over `enqueue` and `dequeue`. On a flush cycle:
  - `population`, `wr_ptr` and `rd_ptr` go to 0.
  - All `buffer` entries go to 0.
  - `data_out` goes to 0.
  - Concurrent enqueue and dequeue are discarded.
- `full` and `empty` are decoded combinationally from the `population` register, so they are glitch-free.
- Reset (`reset_n` low, asynchronous) forces the same state as flush: `data_out=0`, `population=0`, `full=0`, `empty=1`, all `buffer` entries and both pointers 0.
- Reset release is synchronous in effect: the first rising edge with `reset_n` high is a normal cycle.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- All state updates on the rising edge of `clock`.
- Write latency: a word enqueued at edge N is stored after N. `population` and `empty` reflect it after N, and it can be dequeued at edge N+1.
- Read latency: `data_out` shows the dequeued word right after the accepting edge and holds it until the next accepted dequeue, flush or reset.
- `full` asserts after the edge that makes `population == CAPACITY`. It deasserts after the first accepted dequeue.
- No combinational path from `enqueue` or `dequeue` to any output.

## Test plan
All scenarios use `CAPACITY=3`, `BIT_WIDTH=8`, clock period 10.
1. Reset: `reset_n=0` → `population=0`, `empty=1`, `full=0`, `data_out=0`, `buffer={0,0,0}`.
2. Fill: enqueue 100, 255, 120 on three edges → `population` reads 1, 2, 3, `empty` falls after the first edge, `full=1` after the third, `buffer={100,255,120}`.
3. Overflow and drain:
   - Enqueue 7 while full → no change.
   - Then dequeue for four edges → `data_out` reads 100, 255, 120 and `population` reads 2, 1, 0.
   - The fourth dequeue is ignored: `data_out` stays 120, `empty=1`.
4. Wrap-around:
   - From empty with pointers at 0, do enqueue/dequeue cycles until `wr_ptr` passes slot 2.
   - Values 1–5 come out of `data_out` in order, and `population` never exceeds 3.
5. Simultaneous events:
   - With `population=1` (holding 9), enqueue 10 plus dequeue → `data_out=9`, `population=1`.
   - When full, enqueue plus dequeue → only the dequeue is taken, `population=2`.
   - When empty, enqueue plus dequeue → only the enqueue is taken, `population=1`.
6. Flush and reset mid-stream:
   - With `population=2`, `flush=1` together with `enqueue=1` → `population=0`, `buffer={0,0,0}`, `data_out=0`.
   - Dropping `reset_n` between clock edges clears all outputs immediately.
